// File: rtl/brq_ifu_prefetch_ctrl.sv
// Instruction prefetch sequencer: issues word-aligned bus fetches, tracks in-order
// outstanding responses, drops responses made stale by a branch and feeds the fetch FIFO.
module brq_ifu_prefetch_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  output logic                fifo_clear_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i
);

  localparam int unsigned CW = $clog2(NUM_REQS + 1);
  localparam logic [CW:0] NUM_REQS_W = (CW + 1)'(NUM_REQS);

  typedef enum logic {
    IDLE,
    WAIT_GNT
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         fetch_addr_q, fetch_addr_d;
  logic [31:0]         req_addr_q, req_addr_d;
  logic                pending_discard_q, pending_discard_d;
  logic [NUM_REQS-1:0] slot_valid_q, slot_valid_d;
  logic [NUM_REQS-1:0] slot_discard_q, slot_discard_d;

  logic [CW:0]         out_cnt;
  logic [CW:0]         busy_cnt;
  logic                slot_free;
  logic                granted;
  logic                push_discard;
  logic                pop;
  logic                placed;
  logic [31:0]         branch_addr;

  assign branch_addr = {addr_i[31:2], 2'b00};

  // Occupancy counts; a branch clears the FIFO so only bus-side slots limit it.
  always_comb begin
    out_cnt  = '0;
    busy_cnt = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      out_cnt  = out_cnt + (CW + 1)'(slot_valid_q[i]);
      busy_cnt = busy_cnt + (CW + 1)'(fifo_busy_i[i]);
    end
    if (branch_i) begin
      slot_free = (out_cnt < NUM_REQS_W);
    end else begin
      slot_free = ((out_cnt + busy_cnt) < NUM_REQS_W);
    end
  end

  always_comb begin
    state_d           = state_q;
    req_addr_d        = req_addr_q;
    pending_discard_d = pending_discard_q;
    instr_req_o       = 1'b0;
    instr_addr_o      = fetch_addr_q;
    push_discard      = 1'b0;

    case (state_q)
      IDLE: begin
        instr_req_o  = req_i & slot_free;
        instr_addr_o = branch_i ? branch_addr : fetch_addr_q;
        if (instr_req_o && !instr_gnt_i) begin
          state_d           = WAIT_GNT;
          req_addr_d        = instr_addr_o;
          pending_discard_d = 1'b0;
        end
      end
      WAIT_GNT: begin
        // The address must not change under an ungranted request.
        instr_req_o  = 1'b1;
        instr_addr_o = req_addr_q;
        push_discard = pending_discard_q | branch_i;
        if (instr_gnt_i) begin
          state_d           = IDLE;
          pending_discard_d = 1'b0;
        end else if (branch_i) begin
          pending_discard_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign granted = instr_req_o & instr_gnt_i;

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (branch_i) begin
      // Only an IDLE grant in the branch cycle is a fetch of the target itself.
      fetch_addr_d = (state_q == IDLE && granted) ? branch_addr + 32'd4 : branch_addr;
    end else if (granted && !push_discard) begin
      fetch_addr_d = fetch_addr_q + 32'd4;
    end
  end

  // In-order outstanding queue, slot 0 is the oldest: pop, mark stale, then push.
  assign pop = instr_rvalid_i & slot_valid_q[0];

  always_comb begin
    slot_valid_d   = slot_valid_q;
    slot_discard_d = slot_discard_q;
    placed         = 1'b0;
    if (pop) begin
      for (int i = 0; i < NUM_REQS - 1; i++) begin
        slot_valid_d[i]   = slot_valid_q[i+1];
        slot_discard_d[i] = slot_discard_q[i+1];
      end
      slot_valid_d[NUM_REQS-1]   = 1'b0;
      slot_discard_d[NUM_REQS-1] = 1'b0;
    end
    if (branch_i) begin
      slot_discard_d = slot_discard_d | slot_valid_d;
    end
    if (granted) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!slot_valid_d[i] && !placed) begin
          slot_valid_d[i]   = 1'b1;
          slot_discard_d[i] = push_discard;
          placed            = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= IDLE;
      fetch_addr_q      <= '0;
      req_addr_q        <= '0;
      pending_discard_q <= 1'b0;
      slot_valid_q      <= '0;
      slot_discard_q    <= '0;
    end else begin
      state_q           <= state_d;
      fetch_addr_q      <= fetch_addr_d;
      req_addr_q        <= req_addr_d;
      pending_discard_q <= pending_discard_d;
      slot_valid_q      <= slot_valid_d;
      slot_discard_q    <= slot_discard_d;
    end
  end

  assign fifo_valid_o = instr_rvalid_i & slot_valid_q[0] & ~slot_discard_q[0] & ~branch_i;
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = instr_req_o | (|slot_valid_q);

  // A response with nothing outstanding is a bus protocol violation.
  assert property (@(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> slot_valid_q[0]);

endmodule

// File: tb/tb_brq_ifu_prefetch_ctrl.sv
// Directed bench for brq_ifu_prefetch_ctrl; inputs change 1ns after the rising edge,
// outputs are checked 4ns after the rising edge.
module tb_brq_ifu_prefetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        branch_i;
  logic [31:0] addr_i;
  logic        busy_o;
  logic        fifo_clear_o;
  logic [1:0]  fifo_busy_i;
  logic        fifo_valid_o;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_err_o;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk_i = ~clk_i;

  brq_ifu_prefetch_ctrl #(.NUM_REQS(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .busy_o         (busy_o),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_busy_i    (fifo_busy_i),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_err_o     (fifo_err_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_i          = 1'b0;
    branch_i       = 1'b0;
    addr_i         = 32'h0;
    fifo_busy_i    = 2'b00;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    instr_err_i    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #3;
    n_cmp++; if (instr_req_o !== 1'b0) begin n_mis++; $display("FAIL reset_req: got %b expected 0", instr_req_o); end
    n_cmp++; if (instr_addr_o !== 32'h0) begin n_mis++; $display("FAIL reset_addr: got %h expected 0", instr_addr_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_cmp++; if (fifo_valid_o !== 1'b0 || fifo_clear_o !== 1'b0) begin n_mis++; $display("FAIL reset_fifo: got valid=%b clear=%b expected 0/0", fifo_valid_o, fifo_clear_o); end
    $display("reset: req=%b addr=%h busy=%b", instr_req_o, instr_addr_o, busy_o);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_branch_fetch();
    do_reset();
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h100; instr_gnt_i = 1'b1;
    #3;
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin n_mis++; $display("FAIL bf_req: got req=%b addr=%h expected 1/00000100", instr_req_o, instr_addr_o); end
    n_cmp++; if (fifo_clear_o !== 1'b1 || fifo_addr_o !== 32'h100) begin n_mis++; $display("FAIL bf_clear: got clear=%b faddr=%h expected 1/00000100", fifo_clear_o, fifo_addr_o); end
    $display("branch_fetch: req addr=%h", instr_addr_o);
    tick();
    req_i = 1'b0; branch_i = 1'b0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD_BEEF;
    #3;
    n_cmp++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL bf_resp: got valid=%b rdata=%h expected 1/deadbeef", fifo_valid_o, fifo_rdata_o); end
    n_cmp++; if (busy_o !== 1'b1 || instr_addr_o !== 32'h104) begin n_mis++; $display("FAIL bf_next: got busy=%b addr=%h expected 1/00000104", busy_o, instr_addr_o); end
    $display("branch_fetch: resp valid=%b rdata=%h", fifo_valid_o, fifo_rdata_o);
    tick();
    instr_rvalid_i = 1'b0;
    #3;
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL bf_idle: got busy=%b expected 0", busy_o); end
    tick();
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    // A: 0x100 granted, B: 0x104 granted
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h100; instr_gnt_i = 1'b1;
    tick();
    branch_i = 1'b0;
    #3;
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h104) begin n_mis++; $display("FAIL ol_second: got req=%b addr=%h expected 1/00000104", instr_req_o, instr_addr_o); end
    $display("outstanding: second req addr=%h", instr_addr_o);
    tick();
    #3;
    n_cmp++; if (instr_req_o !== 1'b0) begin n_mis++; $display("FAIL ol_full_c: got req=%b expected 0", instr_req_o); end
    tick();
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0000_0001;
    #3;
    n_cmp++; if (instr_req_o !== 1'b0 || fifo_valid_o !== 1'b1) begin n_mis++; $display("FAIL ol_full_d: got req=%b valid=%b expected 0/1", instr_req_o, fifo_valid_o); end
    $display("outstanding: first resp valid=%b req=%b", fifo_valid_o, instr_req_o);
    tick();
    instr_rdata_i = 32'h0000_0002;
    #3;
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h108 || fifo_valid_o !== 1'b1) begin n_mis++; $display("FAIL ol_third: got req=%b addr=%h valid=%b expected 1/00000108/1", instr_req_o, instr_addr_o, fifo_valid_o); end
    $display("outstanding: third req addr=%h", instr_addr_o);
    tick();
    req_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
    tick();
    tick();
    instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0000_0003;
    #3;
    n_cmp++; if (fifo_valid_o !== 1'b1 || instr_addr_o !== 32'h10C) begin n_mis++; $display("FAIL ol_last: got valid=%b addr=%h expected 1/0000010c", fifo_valid_o, instr_addr_o); end
    tick();
    instr_rvalid_i = 1'b0;
    #3;
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL ol_idle: got busy=%b expected 0", busy_o); end
    tick();
  endtask

  task automatic test_branch_wait_gnt();
    do_reset();
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h108; instr_gnt_i = 1'b0;
    tick();
    branch_i = 1'b1; addr_i = 32'h202;
    #3;
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h108 || fifo_clear_o !== 1'b1) begin n_mis++; $display("FAIL bw_hold1: got req=%b addr=%h clear=%b expected 1/00000108/1", instr_req_o, instr_addr_o, fifo_clear_o); end
    tick();
    branch_i = 1'b0; addr_i = 32'h0; req_i = 1'b0;
    #3;
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h108) begin n_mis++; $display("FAIL bw_hold2: got req=%b addr=%h expected 1/00000108", instr_req_o, instr_addr_o); end
    tick();
    instr_gnt_i = 1'b1;
    #3;
    n_cmp++; if (instr_addr_o !== 32'h108) begin n_mis++; $display("FAIL bw_gnt: got addr=%h expected 00000108", instr_addr_o); end
    $display("branch_wait_gnt: granted addr=%h", instr_addr_o);
    tick();
    req_i = 1'b1; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0000_0108;
    #3;
    n_cmp++; if (fifo_valid_o !== 1'b0) begin n_mis++; $display("FAIL bw_drop: got valid=%b expected 0", fifo_valid_o); end
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin n_mis++; $display("FAIL bw_target: got req=%b addr=%h expected 1/00000200", instr_req_o, instr_addr_o); end
    $display("branch_wait_gnt: stale valid=%b next addr=%h", fifo_valid_o, instr_addr_o);
    tick();
    req_i = 1'b0; instr_gnt_i = 1'b0; instr_rdata_i = 32'h0000_0055;
    #3;
    n_cmp++; if (fifo_valid_o !== 1'b1 || instr_addr_o !== 32'h204) begin n_mis++; $display("FAIL bw_resp: got valid=%b addr=%h expected 1/00000204", fifo_valid_o, instr_addr_o); end
    tick();
    instr_rvalid_i = 1'b0;
    tick();
  endtask

  task automatic test_branch_discard();
    do_reset();
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h100; instr_gnt_i = 1'b1;
    tick();
    branch_i = 1'b0;
    tick();
    branch_i = 1'b1; addr_i = 32'h300; instr_gnt_i = 1'b0;
    #3;
    n_cmp++; if (instr_req_o !== 1'b0 || busy_o !== 1'b1) begin n_mis++; $display("FAIL bd_full: got req=%b busy=%b expected 0/1", instr_req_o, busy_o); end
    tick();
    branch_i = 1'b0; addr_i = 32'h0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0000_0100;
    #3;
    n_cmp++; if (fifo_valid_o !== 1'b0 || instr_req_o !== 1'b0) begin n_mis++; $display("FAIL bd_drop1: got valid=%b req=%b expected 0/0", fifo_valid_o, instr_req_o); end
    tick();
    instr_rdata_i = 32'h0000_0104; instr_gnt_i = 1'b1;
    #3;
    n_cmp++; if (fifo_valid_o !== 1'b0) begin n_mis++; $display("FAIL bd_drop2: got valid=%b expected 0", fifo_valid_o); end
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h300) begin n_mis++; $display("FAIL bd_resume: got req=%b addr=%h expected 1/00000300", instr_req_o, instr_addr_o); end
    $display("branch_discard: resume addr=%h", instr_addr_o);
    tick();
    req_i = 1'b0; instr_gnt_i = 1'b0; instr_rdata_i = 32'h0000_CAFE;
    #3;
    n_cmp++; if (fifo_valid_o !== 1'b1 || fifo_rdata_o !== 32'h0000_CAFE) begin n_mis++; $display("FAIL bd_resp: got valid=%b rdata=%h expected 1/0000cafe", fifo_valid_o, fifo_rdata_o); end
    tick();
    instr_rvalid_i = 1'b0;
    #3;
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL bd_idle: got busy=%b expected 0", busy_o); end
    tick();
  endtask

  task automatic test_fifo_busy();
    do_reset();
    req_i = 1'b1; fifo_busy_i = 2'b11;
    #3;
    n_cmp++; if (instr_req_o !== 1'b0 || busy_o !== 1'b0) begin n_mis++; $display("FAIL fb_block1: got req=%b busy=%b expected 0/0", instr_req_o, busy_o); end
    tick();
    #3;
    n_cmp++; if (instr_req_o !== 1'b0) begin n_mis++; $display("FAIL fb_block2: got req=%b expected 0", instr_req_o); end
    tick();
    fifo_busy_i = 2'b00;
    #3;
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin n_mis++; $display("FAIL fb_free: got req=%b addr=%h expected 1/00000000", instr_req_o, instr_addr_o); end
    $display("fifo_busy: req after free=%b", instr_req_o);
    tick();
    fifo_busy_i = 2'b11; instr_gnt_i = 1'b1;
    #3;
    n_cmp++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin n_mis++; $display("FAIL fb_noretract: got req=%b addr=%h expected 1/00000000", instr_req_o, instr_addr_o); end
    tick();
    req_i = 1'b0; instr_gnt_i = 1'b0; fifo_busy_i = 2'b00;
    instr_rvalid_i = 1'b1;
    #3;
    n_cmp++; if (fifo_valid_o !== 1'b1 || instr_addr_o !== 32'h4) begin n_mis++; $display("FAIL fb_resp: got valid=%b addr=%h expected 1/00000004", fifo_valid_o, instr_addr_o); end
    tick();
    instr_rvalid_i = 1'b0;
    tick();
  endtask

  task automatic test_err_response();
    do_reset();
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h40; instr_gnt_i = 1'b1;
    tick();
    req_i = 1'b0; branch_i = 1'b0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1; instr_err_i = 1'b1; instr_rdata_i = 32'h1234_5678;
    #3;
    n_cmp++; if (fifo_valid_o !== 1'b1 || fifo_err_o !== 1'b1) begin n_mis++; $display("FAIL err_resp: got valid=%b err=%b expected 1/1", fifo_valid_o, fifo_err_o); end
    n_cmp++; if (instr_addr_o !== 32'h44) begin n_mis++; $display("FAIL err_advance: got addr=%h expected 00000044", instr_addr_o); end
    $display("err_response: valid=%b err=%b next=%h", fifo_valid_o, fifo_err_o, instr_addr_o);
    tick();
    instr_rvalid_i = 1'b0; instr_err_i = 1'b0;
    tick();
  endtask

  task automatic test_addr_wrap();
    do_reset();
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'hFFFF_FFFE; instr_gnt_i = 1'b1;
    #3;
    n_cmp++; if (instr_addr_o !== 32'hFFFF_FFFC) begin n_mis++; $display("FAIL wrap_align: got addr=%h expected fffffffc", instr_addr_o); end
    tick();
    req_i = 1'b0; branch_i = 1'b0; addr_i = 32'h0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b1;
    #3;
    n_cmp++; if (instr_addr_o !== 32'h0 || fifo_valid_o !== 1'b1) begin n_mis++; $display("FAIL wrap_next: got addr=%h valid=%b expected 00000000/1", instr_addr_o, fifo_valid_o); end
    $display("addr_wrap: next addr=%h", instr_addr_o);
    tick();
    instr_rvalid_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_branch_fetch();
    test_outstanding_limit();
    test_branch_wait_gnt();
    test_branch_discard();
    test_fifo_busy();
    test_err_response();
    test_addr_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
